fp_to_fixed_seq: RTL and testbench
==================================

FP_TO_FIXED_SEQ -- requirements
Module: fp_to_fixed_seq

Interface
REQ-001 SHALL have parameter EXP_W, 8, float exponent width.
REQ-002 SHALL have parameter MAN_W, 23, float stored-mantissa width.
REQ-003 SHALL have parameter INT_W, 16, output integer bits incl. sign; FRAC_W, 16, output fraction bits; W = INT_W+FRAC_W.
REQ-004 SHALL have port CLK input 1, single clock, all state on rising edge.
REQ-005 SHALL have port RST input 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, input handshake.
REQ-007 SHALL have port in_data input 1+EXP_W+MAN_W, IEEE-style float {sign, exp, man}, bias 2^(EXP_W-1)-1.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, output handshake.
REQ-009 SHALL have port out_data output W, two's-complement Q(INT_W).(FRAC_W).
REQ-010 SHALL have ports ovf output 1 (saturated) and inv output 1 (NaN input), valid with out_valid.

Function
REQ-011 SHALL use FSM IDLE -> CHECK -> SHIFT -> FIN -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-012 SHALL capture in_data on in_valid&&in_ready and enter CHECK next cycle.
REQ-013 CHECK SHALL form M = {hidden, man} (hidden=1 if exp!=0, else 0 with exp treated as 1) and k = exp-bias-MAN_W+FRAC_W.
REQ-014 CHECK SHALL classify: exp all-ones, man!=0 -> NaN: result 0, inv=1, go FIN with no shifts.
REQ-015 CHECK SHALL classify: Inf, or normal with MAN_W+k >= W-1 -> saturate to 2^(W-1)-1 (+) or -2^(W-1) (-), ovf=1, no shifts.
REQ-016 CHECK SHALL classify: zero (exp=0, man=0) -> result 0, no shifts, flags 0.
REQ-017 SHIFT SHALL move datapath one bit per cycle, |k| cycles; right shifts clamp at MAN_W+3 cycles and OR lost bits into a sticky bit, keeping guard bit.
REQ-018 FIN SHALL apply rounding per REQ-026/027, then negate if sign=1, in one cycle.
REQ-019 DONE SHALL hold out_valid=1 and stable out_data/ovf/inv until out_ready=1; return to IDLE the cycle after handshake.
REQ-020 Latency accept edge -> out_valid SHALL be 3 + shift-cycle count (3 for special/zero cases).
REQ-021 in_valid while busy SHALL be ignored (no capture, no corruption).
REQ-022 Rounding carry that reaches 2^(W-1) for positive SHALL saturate with ovf=1.

Reset
REQ-023 RST=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, out_data=0, ovf=0, inv=0.
REQ-024 RST asserted mid-conversion SHALL discard the operation; no out_valid after release until a new accept.
REQ-025 First accept SHALL be possible on the first rising edge after RST deasserts.

Configuration
REQ-026 With macro FP2FIX_ROUND_EN defined, FIN SHALL round to nearest, ties to even, using guard and sticky.
REQ-027 Without FP2FIX_ROUND_EN, FIN SHALL truncate magnitude (toward zero); guard/sticky logic removed.

Verification
REQ-028 Defaults, in 32'h3CF5C28F (~0.03) -> out_data 32'h000007AE, ovf=0, inv=0, out_valid 16 cycles after accept (k=-13).
REQ-029 in 32'h3F800000 -> 32'h00010000; in 32'hC0200000 (-2.5) -> 32'hFFFD8000.
REQ-030 in 32'h47800000 (65536.0) -> 32'h7FFFFFFF, ovf=1, latency 3; 32'hFF800000 -> 32'h80000000, ovf=1; 32'h7FC00000 -> 0, inv=1.
REQ-031 in 32'h37C00000 (1.5 LSB) -> 32'h00000002 with FP2FIX_ROUND_EN, 32'h00000001 without.
REQ-032 Hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0; pulse RST during SHIFT -> in_ready=1, out_valid=0, next input converts correctly.

Source files
------------

// File: rtl/fp_to_fixed_seq.sv
// fp_to_fixed_seq: bit-serial float to two's-complement Q(INT_W).(FRAC_W) converter.
// Define FP2FIX_ROUND_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module fp_to_fixed_seq #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16,
  parameter int W      = INT_W + FRAC_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic                   ovf,
  output logic                   inv
);
  localparam int FW   = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int KW   = EXP_W + 8;
  localparam int CW   = $clog2(W + MAN_W + 4);
  localparam int RMAX = MAN_W + 3;
  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, FIN, DONE} state_t;
  state_t r_state, w_next;
  logic [FW-1:0] r_in;
  logic [W-1:0] r_mag, r_out_data;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_left, r_sign, r_ovf, r_inv;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic w_exp_max, w_exp_zero, w_man_zero, w_nan, w_inf, w_big, w_sat, w_special, w_pos, w_up, w_of;
  logic signed [KW-1:0] w_k, w_nk;
  logic [W:0] w_sum;
  logic [W-1:0] w_sat_val, w_res;
  assign w_exp      = r_in[FW-2 -: EXP_W];
  assign w_man      = r_in[MAN_W-1:0];
  assign w_exp_max  = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_man_zero = ~|w_man;
  assign w_nan      = w_exp_max & ~w_man_zero;
  assign w_inf      = w_exp_max & w_man_zero;
  // Subnormals use exponent 1 with a zero hidden bit
  assign w_k  = $signed({{(KW-EXP_W){1'b0}}, w_exp_zero ? EXP_W'(1) : w_exp})
              - $signed(KW'(BIAS + MAN_W - FRAC_W));
  assign w_nk = -w_k;
  assign w_pos     = ~w_k[KW-1] & (|w_k);
  assign w_big     = ~w_exp_zero & (w_k >= $signed(KW'(W - 1 - MAN_W)));
  assign w_sat     = w_inf | (w_big & ~w_exp_max);
  assign w_special = w_nan | w_sat | (w_exp_zero & w_man_zero);
  assign w_cnt = w_special ? '0 : w_pos ? w_k[CW-1:0]
               : (w_nk > $signed(KW'(RMAX))) ? CW'(RMAX) : w_nk[CW-1:0];
`ifdef FP2FIX_ROUND_EN
  logic r_g, r_s;
  assign w_up = r_g & (r_s | r_mag[0]);
`else
  assign w_up = 1'b0;
`endif
  assign w_sum     = {1'b0, r_mag} + (W+1)'(w_up);
  // Magnitude 2^(W-1) is only representable when negative
  assign w_of      = w_sum[W] | (w_sum[W-1] & (~r_sign | (|w_sum[W-2:0])));
  assign w_sat_val = r_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign w_res     = r_inv ? '0 : (r_ovf | w_of) ? w_sat_val
                   : r_sign ? -w_sum[W-1:0] : w_sum[W-1:0];
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? CHECK : IDLE;
      CHECK:   w_next = (w_cnt != '0) ? SHIFT : FIN;
      SHIFT:   w_next = (r_cnt == CW'(1)) ? FIN : SHIFT;
      FIN:     w_next = DONE;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_in       <= '0;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_left     <= 1'b0;
      r_sign     <= 1'b0;
      r_out_data <= '0;
      r_ovf      <= 1'b0;
      r_inv      <= 1'b0;
`ifdef FP2FIX_ROUND_EN
      r_g        <= 1'b0;
      r_s        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) r_in <= in_data;
        CHECK: begin
          r_sign <= r_in[FW-1];
          r_mag  <= w_special ? '0 : W'({~w_exp_zero, w_man});
          r_cnt  <= w_cnt;
          r_left <= w_pos;
          r_ovf  <= w_sat;
          r_inv  <= w_nan;
`ifdef FP2FIX_ROUND_EN
          r_g    <= 1'b0;
          r_s    <= 1'b0;
`endif
        end
        SHIFT: begin
          r_cnt <= r_cnt - CW'(1);
          r_mag <= r_left ? r_mag << 1 : r_mag >> 1;
`ifdef FP2FIX_ROUND_EN
          if (!r_left) begin
            r_g <= r_mag[0];
            r_s <= r_s | r_g;
          end
`endif
        end
        FIN: begin
          r_out_data <= w_res;
          r_ovf      <= r_ovf | w_of;
        end
        default: ;
      endcase
    end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign out_data  = r_out_data;
  assign ovf       = r_ovf;
  assign inv       = r_inv;
endmodule

// File: tb/tb_fp_to_fixed_seq.sv
// tb_fp_to_fixed_seq: directed checks of fp_to_fixed_seq at default parameters.
module tb_fp_to_fixed_seq;
  logic CLK = 1'b0, RST = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, ovf, inv;
  logic [31:0] out_data;
  int n_tests = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  fp_to_fixed_seq dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf), .inv(inv)
  );
  // Latency counts the accept edge as cycle 1; out_valid rises in cycle 3 + shifts
  task automatic convert(input string name, input logic [31:0] d, input logic [31:0] exp_d,
                         input logic exp_ovf, input logic exp_inv, input int exp_lat);
    int lat;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_pre: got %b want 1", name, in_ready); end
    in_valid = 1'b1;
    in_data = d;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge CLK); #1; lat++; end
    n_tests++;
    if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    n_tests++;
    if (out_data !== exp_d) begin n_fail++; $display("FAIL %s data: got %h want %h", name, out_data, exp_d); end
    n_tests++;
    if (ovf !== exp_ovf || inv !== exp_inv)
      begin n_fail++; $display("FAIL %s flags: got ovf=%b inv=%b want ovf=%b inv=%b", name, ovf, inv, exp_ovf, exp_inv); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL %s release: got ready=%b valid=%b want 1 0", name, in_ready, out_valid); end
  endtask
  task automatic test_reset;
    #12;
    n_tests++;
    if ({in_ready, out_valid, out_data, ovf, inv} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL reset: got ready=%b valid=%b data=%h ovf=%b inv=%b want 1 0 0 0 0", in_ready, out_valid, out_data, ovf, inv); end
    RST = 1'b0;
    convert("first_accept", 32'h3F800000, 32'h00010000, 1'b0, 1'b0, 10);
  endtask
  task automatic test_normal;
    convert("q003", 32'h3CF5C28F, 32'h000007AE, 1'b0, 1'b0, 16);
    convert("neg2p5", 32'hC0200000, 32'hFFFD8000, 1'b0, 1'b0, 9);
    convert("k_zero", 32'h43000000, 32'h00800000, 1'b0, 1'b0, 3);
    convert("left7", 32'h46800000, 32'h40000000, 1'b0, 1'b0, 10);
    convert("neg_left7", 32'hC6800000, 32'hC0000000, 1'b0, 1'b0, 10);
  endtask
  task automatic test_special;
    convert("sat_pos", 32'h47800000, 32'h7FFFFFFF, 1'b1, 1'b0, 3);
    convert("sat_neg", 32'hC7800000, 32'h80000000, 1'b1, 1'b0, 3);
    convert("neg_inf", 32'hFF800000, 32'h80000000, 1'b1, 1'b0, 3);
    convert("pos_inf", 32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 3);
    convert("nan", 32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 3);
    convert("zero", 32'h00000000, 32'h00000000, 1'b0, 1'b0, 3);
    convert("neg_zero", 32'h80000000, 32'h00000000, 1'b0, 1'b0, 3);
    convert("subnormal", 32'h00000001, 32'h00000000, 1'b0, 1'b0, 29);
  endtask
  task automatic test_rounding;
`ifdef FP2FIX_ROUND_EN
    convert("lsb1p5", 32'h37C00000, 32'h00000002, 1'b0, 1'b0, 26);
    convert("lsb1p75", 32'h37E00000, 32'h00000002, 1'b0, 1'b0, 26);
    convert("neg_lsb1p5", 32'hB7C00000, 32'hFFFFFFFE, 1'b0, 1'b0, 26);
`else
    convert("lsb1p5", 32'h37C00000, 32'h00000001, 1'b0, 1'b0, 26);
    convert("lsb1p75", 32'h37E00000, 32'h00000001, 1'b0, 1'b0, 26);
    convert("neg_lsb1p5", 32'hB7C00000, 32'hFFFFFFFF, 1'b0, 1'b0, 26);
`endif
    convert("lsb1p25", 32'h37A00000, 32'h00000001, 1'b0, 1'b0, 26);
    convert("lsb2p5_tie", 32'h38200000, 32'h00000002, 1'b0, 1'b0, 25);
  endtask
  task automatic test_busy;
    int busy_acc = 0;
    int t = 0;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    @(posedge CLK); #1;
    in_data = 32'h7FC00000;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0) busy_acc++;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    n_tests++;
    if (busy_acc != 0) begin n_fail++; $display("FAIL busy_ready: got %0d ready cycles want 0", busy_acc); end
    while (out_valid !== 1'b1 && t < 100) begin @(posedge CLK); #1; t++; end
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h00010000 || inv !== 1'b0)
      begin n_fail++; $display("FAIL busy_result: got valid=%b data=%h inv=%b want 1 00010000 0", out_valid, out_data, inv); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_stall;
    int t = 0;
    in_valid = 1'b1;
    in_data = 32'hC0200000;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && t < 100) begin @(posedge CLK); #1; t++; end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFD8000 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL stall_%0d: got valid=%b data=%h ready=%b want 1 fffd8000 0", i, out_valid, out_data, in_ready); end
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL stall_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask
  task automatic test_reset_mid;
    int seen = 0;
    in_valid = 1'b1;
    in_data = 32'h3CF5C28F;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got ready=%b want 0", in_ready); end
    #1 RST = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0)
      begin n_fail++; $display("FAIL mid_reset: got ready=%b valid=%b data=%h want 1 0 0", in_ready, out_valid, out_data); end
    #1 RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_no_output: got %0d valid cycles want 0", seen); end
    convert("after_reset", 32'hC0200000, 32'hFFFD8000, 1'b0, 1'b0, 9);
  endtask
  initial begin
    test_reset;
    test_normal;
    test_special;
    test_rounding;
    test_busy;
    test_stall;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
